// File: rtl/tut_nios_oci_dct_monitor.sv
// OCI trace capture FIFO (first-word-fall-through, 1-cycle capture latency) with valid/ready drain; drops counted when full.
// Optional per-entry timestamps: define TUT_NIOS_OCI_MON_TIMESTAMP_EN.
module tut_nios_oci_dct_monitor #(
  parameter int DCT_WIDTH   = 30,
  parameter int COUNT_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int TS_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DCT_WIDTH-1:0]             dct_buffer,
  input  logic [COUNT_WIDTH-1:0]           dct_count,
  input  logic                             dct_valid,
  input  logic                             test_ending,
  input  logic                             test_has_ended,
  output logic                             mon_valid,
  input  logic                             mon_ready,
  output logic [DCT_WIDTH+COUNT_WIDTH-1:0] mon_data,
  output logic [TS_WIDTH-1:0]              mon_ts,
  output logic                             mon_last,
  output logic [$clog2(DEPTH):0]           fill_level,
  output logic [15:0]                      overflow_cnt,
  output logic                             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = DCT_WIDTH + COUNT_WIDTH;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    ENDED = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] mem [DEPTH];
  logic          full, empty, push_req, push_ok, pop, drop;

  // Extra pointer bit makes full (count==DEPTH) distinct from empty.
  assign count  = wr_ptr - rd_ptr;
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign full   = (count == FULL_LVL);
  assign empty  = (count == '0);

  // A hard stop overrides any push or pop in the same cycle.
  assign push_req = (state == RUN) && dct_valid && (dct_count != '0) && !test_has_ended;
  assign pop      = mon_valid && mon_ready && !test_has_ended;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (test_has_ended)   state_nxt = ENDED;
        else if (test_ending) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (test_has_ended || empty) state_nxt = ENDED;
      end
      ENDED:   state_nxt = ENDED;
      default: state_nxt = ENDED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (test_has_ended) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= {dct_count, dct_buffer};
  end

`ifdef TUT_NIOS_OCI_MON_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) ts_mem[wr_idx] <= ts_cnt;
  end

  assign mon_ts = mon_valid ? ts_mem[rd_idx] : '0;
`else
  assign mon_ts = '0;
`endif

  // Unreset storage is masked so the head reads zero whenever nothing is held.
  assign mon_valid  = !empty;
  assign mon_data   = mon_valid ? mem[rd_idx] : '0;
  assign mon_last   = mon_valid && (state == DRAIN) && (count == PTR_ONE);
  assign fill_level = count;
  assign done       = (state == ENDED);

endmodule

// File: tb/tb_tut_nios_oci_dct_monitor.sv
// Scoreboard bench for tut_nios_oci_dct_monitor: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_tut_nios_oci_dct_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        dct_valid = 1'b0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        mon_valid;
  logic        mon_ready = 1'b0;
  logic [33:0] mon_data;
  logic [15:0] mon_ts;
  logic        mon_last;
  logic [4:0]  fill_level;
  logic [15:0] overflow_cnt;
  logic        done;

  tut_nios_oci_dct_monitor dut (
    .clk(clk), .reset_n(reset_n),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_data(mon_data),
    .mon_ts(mon_ts), .mon_last(mon_last), .fill_level(fill_level),
    .overflow_cnt(overflow_cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] data;
    logic [15:0] ts;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tb_cycle = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cycle <= 0;
    else          tb_cycle <= tb_cycle + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] exp_ts();
`ifdef TUT_NIOS_OCI_MON_TIMESTAMP_EN
    return tb_cycle[15:0];
`else
    return 16'h0;
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && mon_valid && mon_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(mon_data), 64'h0 - 64'h1);
      end else begin
        e = sb.pop_front();
        check("beat_data", 64'(mon_data), 64'(e.data));
        check("beat_ts",   64'(mon_ts),   64'(e.ts));
        check("beat_last", 64'(mon_last), 64'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [3:0] c, input logic [29:0] w, input bit accept, input bit last);
    exp_t e;
    dct_valid  = 1'b1;
    dct_count  = c;
    dct_buffer = w;
    if (accept) begin
      e.data = {c, w};
      e.ts   = exp_ts();
      e.last = last;
      sb.push_back(e);
    end
    tick();
    dct_valid = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    dct_valid = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0; mon_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_empty(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fill_level == 5'd0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  initial begin
    do_reset();
    check("rst_mon_valid", 64'(mon_valid), 64'd0);
    check("rst_mon_data",  64'(mon_data),  64'd0);
    check("rst_mon_ts",    64'(mon_ts),    64'd0);
    check("rst_mon_last",  64'(mon_last),  64'd0);
    check("rst_fill",      64'(fill_level), 64'd0);
    check("rst_overflow",  64'(overflow_cnt), 64'd0);
    check("rst_done",      64'(done),      64'd0);

    // Three words streamed straight through, plus a zero-count strobe that must vanish.
    mon_ready = 1'b1;
    strobe(4'd1, 30'h0000_0AA1, 1'b1, 1'b0);
    strobe(4'd2, 30'h0000_0BB2, 1'b1, 1'b0);
    strobe(4'd3, 30'h3FFF_FFFF, 1'b1, 1'b0);
    wait_empty("stream_drain_bound", 10);
    strobe(4'd0, 30'h0000_1234, 1'b0, 1'b0);
    tick();
    check("stream_fill",     64'(fill_level),   64'd0);
    check("stream_overflow", 64'(overflow_cnt), 64'd0);
    check("zero_count_valid", 64'(mon_valid),   64'd0);
    mon_ready = 1'b0;

    // Overfill by four, then push and pop together while full.
    for (int i = 0; i < 20; i++) strobe(4'hA, 30'(100 + i), i < 16, 1'b0);
    check("full_fill",     64'(fill_level),   64'd16);
    check("full_overflow", 64'(overflow_cnt), 64'd4);
    mon_ready = 1'b1;
    strobe(4'hC, 30'd999, 1'b1, 1'b0);
    mon_ready = 1'b0;
    check("pushpop_fill",     64'(fill_level),   64'd16);
    check("pushpop_overflow", 64'(overflow_cnt), 64'd4);
    mon_ready = 1'b1;
    wait_empty("full_drain_bound", 40);
    mon_ready = 1'b0;
    check("after_full_overflow", 64'(overflow_cnt), 64'd4);

    // Five held, sixth captured alongside test_ending; only the sixth beat is last.
    for (int i = 0; i < 5; i++) strobe(4'h5, 30'(200 + i), 1'b1, 1'b0);
    test_ending = 1'b1;
    strobe(4'h6, 30'd205, 1'b1, 1'b1);
    test_ending = 1'b0;
    check("drain_fill6", 64'(fill_level), 64'd6);
    check("drain_done0", 64'(done),       64'd0);
    dct_valid = 1'b1; dct_count = 4'h7; dct_buffer = 30'h777;
    mon_ready = 1'b1;
    wait_empty("drain_bound", 20);
    check("drain_done_at_empty", 64'(done), 64'd0);
    tick();
    check("drain_done", 64'(done), 64'd1);
    tick();
    tick();
    check("ended_ignore_valid", 64'(mon_valid),  64'd0);
    check("ended_ignore_fill",  64'(fill_level), 64'd0);
    dct_valid = 1'b0;
    mon_ready = 1'b0;

    // Hard stop with eight held, beating a concurrent test_ending and push.
    do_reset();
    for (int i = 0; i < 8; i++) strobe(4'h8, 30'(300 + i), 1'b1, 1'b0);
    check("hard_pre_fill", 64'(fill_level), 64'd8);
    test_has_ended = 1'b1;
    test_ending    = 1'b1;
    sb.delete();
    strobe(4'h9, 30'd399, 1'b0, 1'b0);
    test_has_ended = 1'b0;
    test_ending    = 1'b0;
    check("hard_fill",  64'(fill_level), 64'd0);
    check("hard_valid", 64'(mon_valid),  64'd0);
    check("hard_done",  64'(done),       64'd1);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    for (int i = 0; i < 3; i++) strobe(4'h3, 30'(400 + i), 1'b0, 1'b0);
    check("hard_after_fill", 64'(fill_level), 64'd0);
    check("hard_after_done", 64'(done),       64'd1);

    // Asynchronous reset while full with drops recorded.
    do_reset();
    for (int i = 0; i < 18; i++) strobe(4'h2, 30'(500 + i), i < 16, 1'b0);
    check("pre_arst_overflow", 64'(overflow_cnt), 64'd2);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid",    64'(mon_valid),    64'd0);
    check("arst_data",     64'(mon_data),     64'd0);
    check("arst_fill",     64'(fill_level),   64'd0);
    check("arst_overflow", 64'(overflow_cnt), 64'd0);
    check("arst_done",     64'(done),         64'd0);
    sb.delete();
    do_reset();

    // Saturating drop counter, then the held words still drain in order.
    for (int i = 0; i < 16; i++) strobe(4'h4, 30'(600 + i), 1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) strobe(4'h4, 30'h1F0F0, 1'b0, 1'b0);
    check("sat_overflow", 64'(overflow_cnt), 64'hFFFF);
    check("sat_fill",     64'(fill_level),   64'd16);
    mon_ready = 1'b1;
    wait_empty("sat_drain_bound", 40);
    mon_ready = 1'b0;
    check("sat_overflow_hold", 64'(overflow_cnt), 64'hFFFF);

    tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
